// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron sequencer: opcodes, FSM states, output clamp.
package neuron_pkg;

  localparam logic [1:0] OP_WR_IN = 2'b00;
  localparam logic [1:0] OP_WR_W  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Width used to hand a shifted accumulator to the clamp; ACC_W must not exceed it.
  localparam int CLAMP_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARG     = 2'd1,
    COMPUTE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  // ReLU plus saturation to an unsigned byte.
  function automatic logic [7:0] clamp_u8(input logic signed [CLAMP_W-1:0] s);
    if (s < 0) begin
      return 8'd0;
    end else if (s > 64'sd255) begin
      return 8'hFF;
    end else begin
      return s[7:0];
    end
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered signed multiply-accumulate: unsigned 8-bit x times signed 8-bit w.
module neuron_mac #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [7:0]              x,
  input  logic signed [7:0]       w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Product is 17-bit signed: x is zero-extended to 9 bits before the multiply.
  always_comb begin
    prod  = 17'($signed({1'b0, x})) * 17'(w);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Command decoder and MAC sequencer between the SPI byte receiver and the neuron datapath.
// rx handshake: a byte is taken in any cycle rx_valid is high (no back-pressure);
// while busy the byte is discarded and frame_err strobes in that same cycle.
module neuron_seq_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int ACC_W      = 20,
  parameter int OUT_SHIFT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic [7:0] neuronout,
  output logic       result_valid,
  output logic       frame_err
);

  // Counter must be able to hold NUM_INPUTS after the final increment.
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [5:0]              idx_q, idx_d;
  logic                    entry_q, entry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              x_q [NUM_INPUTS];
  logic [7:0]              x_d [NUM_INPUTS];
  logic signed [7:0]       w_q [NUM_INPUTS];
  logic signed [7:0]       w_d [NUM_INPUTS];
  logic [7:0]              out_q, out_d;
  logic                    rv_q, rv_d;

  logic                    mac_clr;
  logic                    mac_en;
  logic [7:0]              mac_x;
  logic signed [7:0]       mac_w;
  logic signed [ACC_W-1:0] acc;

  neuron_mac #(.ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .x   (mac_x),
    .w   (mac_w),
    .acc (acc)
  );

  // Select the operand pair addressed by the compute counter.
  always_comb begin
    mac_x = '0;
    mac_w = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        mac_x = x_q[i];
        mac_w = w_q[i];
      end
    end
  end

  // Next-state, operand writes, MAC control and result capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    entry_d   = 1'b0;
    cnt_d     = cnt_q;
    x_d       = x_q;
    w_d       = w_q;
    out_d     = out_q;
    rv_d      = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          op_d  = rx_data[7:6];
          idx_d = rx_data[5:0];
          case (rx_data[7:6])
            OP_WR_IN, OP_WR_W: begin
              state_d = ARG;
              if ({1'b0, rx_data[5:0]} >= 7'(NUM_INPUTS)) begin
                frame_err = 1'b1;
              end
            end
            OP_START: begin
              state_d = COMPUTE;
              entry_d = 1'b1;
            end
            OP_CLEAR: begin
              x_d = '{default: '0};
              w_d = '{default: '0};
            end
          endcase
        end
      end
      ARG: begin
        // An out-of-range index matches no slot, so the operand is simply consumed.
        if (rx_valid) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if ({1'b0, idx_q} == 7'(i)) begin
              if (op_q == OP_WR_IN) begin
                x_d[i] = rx_data;
              end else begin
                w_d[i] = rx_data;
              end
            end
          end
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        frame_err = rx_valid;
        if (entry_q) begin
          mac_clr = 1'b1;
          cnt_d   = '0;
        end else begin
          mac_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        frame_err = rx_valid;
        out_d     = clamp_u8(CLAMP_W'(acc >>> OUT_SHIFT));
        rv_d      = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // State, operand file and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      entry_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '{default: '0};
      w_q     <= '{default: '0};
      out_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      w_q     <= w_d;
      out_q   <= out_d;
      rv_q    <= rv_d;
    end
  end

  assign busy         = (state_q == COMPUTE) || (state_q == FINISH);
  assign neuronout    = out_q;
  assign result_valid = rv_q;

endmodule
